// File: rtl/sys_skew_feeder_if.sv
// rtl/sys_skew_feeder_if.sv - frame control, input and output stream bundle for the skew feeder
interface sys_skew_feeder_if #(
    parameter int ROWS  = 5,
    parameter int DW    = 8,
    parameter int LEN_W = 8
);
    logic                      start;
    logic [LEN_W-1:0]          len;
    logic                      skew_en;
    logic                      ready;
    logic                      in_valid;
    logic [ROWS-1:0][DW-1:0]   in_data;
    logic                      in_ready;
    logic                      stall;
    logic                      out_valid;
    logic [ROWS-1:0][DW-1:0]   out_data;
    logic                      done;

    modport master (
        output start, len, skew_en, in_valid, in_data, stall,
        input  ready, in_ready, out_valid, out_data, done
    );

    modport slave (
        input  start, len, skew_en, in_valid, in_data, stall,
        output ready, in_ready, out_valid, out_data, done
    );
endinterface

// File: rtl/sys_skew_feeder.sv
// rtl/sys_skew_feeder.sv - framed input-skew stage producing the systolic wavefront
module sys_skew_feeder #(
    parameter int ROWS  = 5,
    parameter int DW    = 8,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    sys_skew_feeder_if.slave  bus
);
    // Lane r owns an r-deep chain; all chains live in one triangular tap array.
    localparam int FW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int NTAP = (ROWS > 1) ? (ROWS * (ROWS - 1)) / 2 : 1;

    function automatic int tap_base(input int r);
        return (r * (r - 1)) / 2;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic                    skew_q, skew_d;
    logic [FW-1:0]           fl_q, fl_d;
    logic                    adv;
    logic [ROWS-1:0][DW-1:0] lane_in;
    logic [DW-1:0]           tap_q [NTAP];
    logic [ROWS-1:0][DW-1:0] out_q;
    logic                    out_valid_q;

    // In FLUSH the zero vector is shifted in so chains drain and end cleared.
    assign lane_in      = (state_q == S_FEED) ? bus.in_data : '0;
    assign bus.in_ready = (state_q == S_FEED) && !bus.stall;
    assign adv          = ((state_q == S_FEED) && bus.in_valid && !bus.stall) ||
                          ((state_q == S_FLUSH) && !bus.stall);
    assign bus.ready     = (state_q == S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q;

    // Frame controller state and latched frame parameters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            skew_q  <= 1'b0;
            fl_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            skew_q  <= skew_d;
            fl_q    <= fl_d;
        end
    end

    // Next-state: count accepted vectors, then ROWS-1 flush advances when skewing.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        skew_d  = skew_q;
        fl_d    = fl_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    len_d   = bus.len;
                    skew_d  = bus.skew_en;
                    cnt_d   = '0;
                    fl_d    = '0;
                    state_d = (bus.len == '0) ? S_DONE : S_FEED;
                end
            end
            S_FEED: begin
                if (adv) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == len_q) begin
                        fl_d    = '0;
                        state_d = (skew_q && (ROWS > 1)) ? S_FLUSH : S_DONE;
                    end
                end
            end
            S_FLUSH: begin
                if (adv) begin
                    fl_d = fl_q + 1'b1;
                    if (fl_q + 1'b1 == FW'(ROWS - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Shift every lane chain by one on each advance while skewing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NTAP; i++) begin
                tap_q[i] <= '0;
            end
        end else if (adv && skew_q) begin
            for (int r = 1; r < ROWS; r++) begin
                tap_q[tap_base(r)] <= lane_in[r];
                for (int k = 1; k < r; k++) begin
                    tap_q[tap_base(r) + k] <= tap_q[tap_base(r) + k - 1];
                end
            end
        end
    end

    // Register the wavefront: chain tails when skewing, the raw input in bypass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= adv;
            if (adv) begin
                out_q[0] <= lane_in[0];
                for (int r = 1; r < ROWS; r++) begin
                    out_q[r] <= skew_q ? tap_q[tap_base(r) + r - 1] : lane_in[r];
                end
            end
        end
    end
endmodule

// File: tb/tb_sys_skew_feeder.sv
// tb/tb_sys_skew_feeder.sv - directed self-checking bench for sys_skew_feeder
module tb_sys_skew_feeder;
    localparam int ROWS  = 5;
    localparam int DW    = 8;
    localparam int LEN_W = 8;

    typedef logic [ROWS-1:0][DW-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sys_skew_feeder_if #(.ROWS(ROWS), .DW(DW), .LEN_W(LEN_W)) bus ();

    sys_skew_feeder #(.ROWS(ROWS), .DW(DW), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    vec_t beats [64];
    int   nbeats;

    function automatic vec_t vec(input int k);
        vec_t v;
        for (int r = 0; r < ROWS; r++) v[r] = DW'(16 * (k + 1) + r);
        return v;
    endfunction

    function automatic vec_t model(input int j, input int len, input bit skew);
        vec_t v;
        int   k;
        for (int r = 0; r < ROWS; r++) begin
            k    = skew ? (j - r) : j;
            v[r] = (k >= 0 && k < len) ? DW'(16 * (k + 1) + r) : '0;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic frame(input int len, input bit skew, input int stall_after, input int stall_n,
                         input int gap_after, input int gap_n);
        int  vi, stall_left, gap_left, total;
        bit  acc, done_seen, was_stalled;
        total = (len == 0) ? 0 : (skew ? len + ROWS - 1 : len);
        nbeats = 0; vi = 0; stall_left = 0; gap_left = 0; done_seen = 0; was_stalled = 0;
        bus.start = 1'b1; bus.len = LEN_W'(len); bus.skew_en = skew;
        bus.in_valid = 1'b0; bus.stall = 1'b0; bus.in_data = '0;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        chk("busy_ready", 64'(bus.ready), 64'(0));
        for (int cyc = 0; cyc < 100 && !done_seen; cyc++) begin
            if (was_stalled) begin
                chk("stall_out_valid", 64'(bus.out_valid), 64'(0));
                chk("stall_hold", 64'(bus.out_data), 64'(model(stall_after, len, skew)));
            end
            if (bus.out_valid) begin
                chk($sformatf("beat%0d", nbeats), 64'(bus.out_data), 64'(model(nbeats, len, skew)));
                beats[nbeats] = bus.out_data;
                nbeats++;
                if (nbeats - 1 == stall_after) stall_left = stall_n;
            end
            if (bus.done) begin
                done_seen = 1;
                chk("done_out_valid", 64'(bus.out_valid), 64'(total > 0));
                chk("beat_count", 64'(nbeats), 64'(total));
            end else begin
                bus.stall    = (stall_left > 0);
                bus.in_valid = (vi < len) && (gap_left == 0);
                bus.in_data  = (vi < len) ? vec(vi) : '0;
                #1;
                if (bus.stall) chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
                acc = bus.in_valid && bus.in_ready;
                @(posedge clk);
                was_stalled = bus.stall;
                if (stall_left > 0) stall_left--;
                if (gap_left > 0) gap_left--;
                if (acc) begin
                    if (vi == gap_after) gap_left = gap_n;
                    vi++;
                end
                @(negedge clk);
            end
        end
        chk("done_seen", 64'(done_seen), 64'(1));
        bus.in_valid = 1'b0; bus.stall = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("post_ready", 64'(bus.ready), 64'(1));
        chk("post_done", 64'(bus.done), 64'(0));
        chk("post_out_valid", 64'(bus.out_valid), 64'(0));
    endtask

    initial begin
        bus.start = 1'b0; bus.len = '0; bus.skew_en = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.stall = 1'b0;

        // 1: reset values, then held after release
        #1 rst = 1'b0;
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_ready", 64'(bus.ready), 64'(1));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rel_ready", 64'(bus.ready), 64'(1));
        chk("rel_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rel_out_data", 64'(bus.out_data), 64'(0));

        // 2: basic skewed frame
        frame(3, 1'b1, -1, 0, -1, 0);
        chk("c2_beat0", 64'(beats[0]), 64'h00_00_00_00_10);
        chk("c2_beat2", 64'(beats[2]), 64'h00_00_12_21_30);
        chk("c2_beat6", 64'(beats[6]), 64'h34_00_00_00_00);

        // 3: two stall cycles after beat1
        frame(3, 1'b1, 1, 2, -1, 0);
        chk("c3_beat1", 64'(beats[1]), 64'h00_00_00_11_20);
        chk("c3_beat6", 64'(beats[6]), 64'h34_00_00_00_00);

        // 4: three-cycle input gap between v1 and v2
        frame(3, 1'b1, -1, 0, 1, 3);
        chk("c4_beat2", 64'(beats[2]), 64'h00_00_12_21_30);

        // 5: bypass frame and empty frame
        frame(2, 1'b0, -1, 0, -1, 0);
        chk("c5_beat0", 64'(beats[0]), 64'h14_13_12_11_10);
        chk("c5_beat1", 64'(beats[1]), 64'h24_23_22_21_20);
        frame(0, 1'b1, -1, 0, -1, 0);

        // 6: busy start ignored, reset during FLUSH, then a clean frame
        bus.start = 1'b1; bus.len = LEN_W'(3); bus.skew_en = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1; bus.in_data = vec(k);
            @(posedge clk); @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("c6_flush_in_ready", 64'(bus.in_ready), 64'(0));
        bus.start = 1'b1; bus.len = LEN_W'(0); bus.skew_en = 1'b0;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        chk("c6_busy_ready", 64'(bus.ready), 64'(0));
        chk("c6_beat3", 64'(bus.out_data), 64'(model(3, 3, 1'b1)));
        chk("c6_beat3_valid", 64'(bus.out_valid), 64'(1));
        rst = 1'b0;
        #1;
        chk("c6_rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("c6_rst_out_data", 64'(bus.out_data), 64'(0));
        chk("c6_rst_ready", 64'(bus.ready), 64'(1));
        chk("c6_rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("c6_rst_done", 64'(bus.done), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        frame(3, 1'b1, -1, 0, -1, 0);
        chk("c6_beat0", 64'(beats[0]), 64'h00_00_00_00_10);
        chk("c6_beat2", 64'(beats[2]), 64'h00_00_12_21_30);
        chk("c6_beat6", 64'(beats[6]), 64'h34_00_00_00_00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
